// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares the single instruction-RAM port between the fetch
// stage (reads) and the program loader / debug writer (writes).
//
// Handshake: the loader holds ld_req_i with ld_addr_i/ld_data_i stable until
// it sees ld_ack_o high in the same cycle; that cycle is the RAM write. Fetch
// must stall while fetch_hold_o is high. instr_valid_o marks instr_o as the
// data for the read issued on the previous cycle.
//
// After reset the CPU is held in LOAD while the RAM is filled. In RUN, fetch
// owns the port until the loader asks. A WRITE burst of at most MAX_BURST
// writes follows, then a one-cycle REPLAY re-reads the held fetch address.
// dbg_state_o exposes the FSM state for checkers.
module imem_port_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [ADDR_W-1:0] fetch_addr_i,
    input  logic              fetch_stall_i,
    output logic [DATA_W-1:0] instr_o,
    output logic              instr_valid_o,
    output logic              fetch_hold_o,
    input  logic              ld_req_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic [DATA_W-1:0] ld_data_i,
    output logic              ld_ack_o,
    input  logic              ld_done_i,
    output logic              ram_write_en_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_data_o,
    input  logic [DATA_W-1:0] ram_instr_i,
    output logic [1:0]        dbg_state_o
);

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        RUN    = 2'd1,
        WRITE  = 2'd2,
        REPLAY = 2'd3
    } state_t;

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    state_t             state;
    logic [ADDR_W-1:0]  stored_addr;
    logic [CNT_W-1:0]   burst_cnt;
    logic               write_cyc;
    logic               read_cyc;

    assign dbg_state_o = state;
    assign instr_o     = ram_instr_i;

    // A cycle is a write only when the loader owns the port and is asking;
    // a cycle with reset asserted never writes, so an in-flight burst is dropped.
    always_comb begin
        write_cyc = reset_i && ld_req_i && ((state == LOAD) || (state == WRITE));
        read_cyc  = reset_i && ((state == RUN) || (state == REPLAY));
    end

    // Port mux: loader write, live fetch address, or the held fetch address.
    always_comb begin
        ram_write_en_o = write_cyc;
        ld_ack_o       = write_cyc;
        ram_data_o     = write_cyc ? ld_data_i : '0;
        fetch_hold_o   = !(reset_i && (state == RUN));
        if (write_cyc) begin
            ram_addr_o = ld_addr_i;
        end else if (reset_i && (state == RUN)) begin
            ram_addr_o = fetch_stall_i ? stored_addr : fetch_addr_i;
        end else begin
            ram_addr_o = stored_addr;
        end
    end

    // Mode sequencing, held fetch address, burst length and read-valid flag.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state         <= LOAD;
            stored_addr   <= '0;
            burst_cnt     <= '0;
            instr_valid_o <= 1'b0;
        end else begin
            instr_valid_o <= read_cyc;
            case (state)
                LOAD: begin
                    if (ld_done_i) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    stored_addr <= ram_addr_o;
                    if (ld_req_i) begin
                        state     <= WRITE;
                        burst_cnt <= '0;
                    end
                end
                WRITE: begin
                    if (ld_req_i) begin
                        if (burst_cnt == CNT_W'(MAX_BURST - 1)) begin
                            state     <= REPLAY;
                            burst_cnt <= '0;
                        end else begin
                            burst_cnt <= burst_cnt + 1'b1;
                        end
                    end else begin
                        state     <= REPLAY;
                        burst_cnt <= '0;
                    end
                end
                REPLAY: begin
                    state <= RUN;
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: directed vectors with literal expectations,
// a behavioural model of port ownership checked every cycle, and a simple
// synchronous RAM that answers the DUT's port.
module tb_imem_port_arbiter;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 16;
    localparam int MAX_BURST = 8;

    logic              clk_i = 1'b0;
    logic              reset_i;
    logic [ADDR_W-1:0] fetch_addr_i;
    logic              fetch_stall_i;
    logic [DATA_W-1:0] instr_o;
    logic              instr_valid_o;
    logic              fetch_hold_o;
    logic              ld_req_i;
    logic [ADDR_W-1:0] ld_addr_i;
    logic [DATA_W-1:0] ld_data_i;
    logic              ld_ack_o;
    logic              ld_done_i;
    logic              ram_write_en_o;
    logic [ADDR_W-1:0] ram_addr_o;
    logic [DATA_W-1:0] ram_data_o;
    logic [DATA_W-1:0] ram_instr_i;
    logic [1:0]        dbg_state_o;

    int n_chk  = 0;
    int n_pass = 0;

    imem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .fetch_addr_i(fetch_addr_i), .fetch_stall_i(fetch_stall_i),
        .instr_o(instr_o), .instr_valid_o(instr_valid_o), .fetch_hold_o(fetch_hold_o),
        .ld_req_i(ld_req_i), .ld_addr_i(ld_addr_i), .ld_data_i(ld_data_i),
        .ld_ack_o(ld_ack_o), .ld_done_i(ld_done_i),
        .ram_write_en_o(ram_write_en_o), .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o),
        .ram_instr_i(ram_instr_i), .dbg_state_o(dbg_state_o)
    );

    // ---------------- clock ----------------
    always #5 clk_i = ~clk_i;

    // ---------------- RAM attached to the port ----------------
    logic [DATA_W-1:0] ram_mem [logic [ADDR_W-1:0]];
    always @(posedge clk_i) begin
        if (ram_write_en_o) begin
            ram_mem[ram_addr_o] = ram_data_o;
        end else begin
            ram_instr_i <= ram_mem.exists(ram_addr_o) ? ram_mem[ram_addr_o] : '0;
        end
    end

    // ---------------- checking helper ----------------
    task automatic chk(input string name, input logic [ADDR_W-1:0] act, input logic [ADDR_W-1:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Who owns the port: boot loader until done, then fetch, except during a
    // loader burst (at most MAX_BURST writes) and the single re-read after it.
    bit                m_booted     = 0;
    bit                m_in_burst   = 0;
    bit                m_replay_due = 0;
    int                m_burst_n    = 0;
    logic [ADDR_W-1:0] m_held       = '0;
    bit                m_valid      = 0;
    logic [DATA_W-1:0] m_instr      = '0;
    logic [DATA_W-1:0] m_mem [logic [ADDR_W-1:0]];

    function automatic logic [DATA_W-1:0] m_read(input logic [ADDR_W-1:0] a);
        return m_mem.exists(a) ? m_mem[a] : '0;
    endfunction

    // Compare on the falling edge, then advance the model over the next rising edge.
    initial begin
        bit                e_we;
        bit                e_hold;
        logic [ADDR_W-1:0] e_addr;
        bit                n_valid;
        logic [DATA_W-1:0] n_instr;
        forever begin
            @(negedge clk_i);
            n_valid = 0;
            n_instr = '0;
            e_we    = 0;
            e_hold  = 1;
            e_addr  = m_held;
            if (!reset_i) begin
                m_booted = 0; m_in_burst = 0; m_replay_due = 0;
                m_burst_n = 0; m_held = '0;
            end else if (!m_booted) begin
                if (ld_req_i) begin e_we = 1; e_addr = ld_addr_i; end
                if (ld_done_i) m_booted = 1;
            end else if (m_in_burst) begin
                if (ld_req_i) begin
                    e_we = 1; e_addr = ld_addr_i;
                    m_burst_n++;
                    if (m_burst_n == MAX_BURST) begin m_in_burst = 0; m_replay_due = 1; end
                end else begin
                    m_in_burst = 0; m_replay_due = 1;
                end
            end else if (m_replay_due) begin
                m_replay_due = 0;
                n_valid = 1; n_instr = m_read(m_held);
            end else begin
                e_hold = 0;
                e_addr = fetch_stall_i ? m_held : fetch_addr_i;
                m_held = e_addr;
                n_valid = 1; n_instr = m_read(e_addr);
                if (ld_req_i) begin m_in_burst = 1; m_burst_n = 0; end
            end
            chk("m_we",    ram_write_en_o, e_we);
            chk("m_ack",   ld_ack_o,       e_we);
            chk("m_hold",  fetch_hold_o,   e_hold);
            chk("m_addr",  ram_addr_o,     e_addr);
            chk("m_data",  ram_data_o,     e_we ? ld_data_i : '0);
            chk("m_valid", instr_valid_o,  m_valid);
            if (m_valid) chk("m_instr", instr_o, m_instr);
            if (e_we) m_mem[e_addr] = ld_data_i;
            m_valid = n_valid;
            m_instr = n_instr;
        end
    end

    // ---------------- driver ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic ld(input bit req, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input bit done);
        ld_req_i = req; ld_addr_i = a; ld_data_i = d; ld_done_i = done;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int acks;
        int run_len;
        int max_run;
        reset_i = 1'b0; fetch_addr_i = '0; fetch_stall_i = 1'b0;
        ld(0, '0, '0, 0);

        // reset for two edges
        cyc(1);
        @(negedge clk_i);
        chk("rst_hold",  fetch_hold_o,   1);
        chk("rst_valid", instr_valid_o,  0);
        chk("rst_we",    ram_write_en_o, 0);
        chk("rst_state", dbg_state_o,    0);
        cyc(1);

        // boot load: two writes, done with the second
        reset_i = 1'b1;
        ld(1, 32'h0, 16'h1111, 0);
        @(negedge clk_i);
        chk("boot_ack0", ld_ack_o,   1);
        chk("boot_adr0", ram_addr_o, 32'h0);
        cyc(1);
        ld(1, 32'h2, 16'h2222, 1);
        @(negedge clk_i);
        chk("boot_ack1",  ld_ack_o,     1);
        chk("boot_hold1", fetch_hold_o, 1);
        cyc(1);
        ld(0, '0, '0, 0);
        fetch_addr_i = 32'h0;
        @(negedge clk_i);
        chk("run_hold", fetch_hold_o, 0);
        chk("run_addr", ram_addr_o,   32'h0);
        cyc(1);
        fetch_addr_i = 32'h2;
        @(negedge clk_i);
        chk("first_valid", instr_valid_o, 1);
        chk("first_instr", instr_o,       16'h1111);

        // stall: address 0x2 is re-presented while fetch_addr_i moves on
        cyc(1);
        fetch_stall_i = 1'b1; fetch_addr_i = 32'h4;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("stall_addr",  ram_addr_o,    32'h2);
            chk("stall_valid", instr_valid_o, 1);
            chk("stall_instr", instr_o,       16'h2222);
            cyc(1);
        end

        // mid-run two-write burst, then replay of 0x2
        fetch_stall_i = 1'b0; fetch_addr_i = 32'h2;
        ld(1, 32'h8, 16'hABCD, 0);
        @(negedge clk_i);
        chk("mw_fetch_ack",  ld_ack_o,     0);
        chk("mw_fetch_hold", fetch_hold_o, 0);
        cyc(1);
        @(negedge clk_i);
        chk("mw_ack1",  ld_ack_o,     1);
        chk("mw_hold1", fetch_hold_o, 1);
        cyc(1);
        ld(1, 32'hA, 16'h1234, 0);
        @(negedge clk_i);
        chk("mw_ack2", ld_ack_o, 1);
        cyc(1);
        ld(0, '0, '0, 0);
        @(negedge clk_i);
        chk("mw_idle_ack", ld_ack_o, 0);
        cyc(1);
        @(negedge clk_i);
        chk("replay_addr", ram_addr_o,   32'h2);
        chk("replay_hold", fetch_hold_o, 1);
        cyc(1);
        fetch_addr_i = 32'h8;
        @(negedge clk_i);
        chk("replay_valid", instr_valid_o, 1);
        chk("replay_instr", instr_o,       16'h2222);
        cyc(1);
        fetch_addr_i = 32'hA;
        @(negedge clk_i);
        chk("new_instr", instr_o, 16'hABCD);
        cyc(1);

        // burst cap: request held for 20 cycles
        acks = 0; run_len = 0; max_run = 0;
        for (int i = 0; i < 20; i++) begin
            ld(1, 32'h100 + 32'(2 * i), 16'($urandom_range(0, 16'hFFFF)), 0);
            @(negedge clk_i);
            if (ld_ack_o === 1'b1) begin
                acks++; run_len++;
                if (run_len > max_run) max_run = run_len;
            end else begin
                run_len = 0;
            end
            cyc(1);
        end
        chk("burst_acks",    acks,    16);
        chk("burst_maxrun",  max_run, MAX_BURST);
        ld(0, '0, '0, 0);
        fetch_addr_i = 32'h104;
        cyc(4);

        // reset during the third write of a burst
        ld(1, 32'h40, 16'h7777, 0);
        cyc(3);
        reset_i = 1'b0;
        cyc(1);
        reset_i = 1'b1;
        ld(0, '0, '0, 0);
        @(negedge clk_i);
        chk("mrst_we",    ram_write_en_o, 0);
        chk("mrst_valid", instr_valid_o,  0);
        chk("mrst_hold",  fetch_hold_o,   1);
        chk("mrst_state", dbg_state_o,    0);
        cyc(1);

        // simultaneous done and write in LOAD
        ld(1, 32'h20, 16'h5A5A, 1);
        @(negedge clk_i);
        chk("done_ack", ld_ack_o, 1);
        cyc(1);
        ld(0, '0, '0, 1);
        fetch_addr_i = 32'h20;
        @(negedge clk_i);
        chk("done_hold", fetch_hold_o, 0);
        cyc(1);
        ld_done_i = 1'b0;
        @(negedge clk_i);
        chk("done_instr", instr_o, 16'h5A5A);
        cyc(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
Owns the single port of the instruction RAM and shares it between the fetch stage (read) and the program loader/debug writer (write). After reset it holds the CPU while the loader fills the RAM. It then hands the port to fetch, pre-empting fetch for bounded write bursts. It replays the held fetch address after each burst so the pipeline sees a valid instruction again.

Parameters:
ADDR_W, 32, width of fetch and loader addresses (WORD)
DATA_W, 16, instruction width (HALF_WORD)
MAX_BURST, 8, maximum consecutive loader writes in RUN before fetch regains the port (>=1)

Ports:
clk_i  input  1  clock; all logic on rising edge
reset_i  input  1  reset; synchronous, active-low
fetch_addr_i  input  ADDR_W  program counter from fetch
fetch_stall_i  input  1  pipeline stall; re-present last issued fetch address
instr_o  output  DATA_W  instruction to decode (pass-through of ram_instr_i)
instr_valid_o  output  1  instr_o holds data for a fetch read issued last cycle
fetch_hold_o  output  1  port not available to fetch; pipeline must stall
ld_req_i  input  1  loader write request
ld_addr_i  input  ADDR_W  loader write address
ld_data_i  input  DATA_W  loader write data
ld_ack_o  output  1  write performed this cycle
ld_done_i  input  1  boot load complete (meaningful in LOAD only)
ram_write_en_o  output  1  RAM write strobe
ram_addr_o  output  ADDR_W  RAM address
ram_data_o  output  DATA_W  RAM write data
ram_instr_i  input  DATA_W  RAM read data; 1-cycle synchronous latency

Behaviour:
- States: LOAD, RUN, WRITE, REPLAY. Reset state is LOAD.
- Reset (reset_i==0 at a clk edge, any state, including mid-burst): state=LOAD, stored_addr=0, burst_cnt=0, instr_valid_o=0. Any write in progress is abandoned.
- Combinational outputs in reset/LOAD idle: ram_write_en_o=0, ld_ack_o=0, fetch_hold_o=1.
- Write cycle (LOAD or WRITE with ld_req_i=1):
  - ram_write_en_o=1, ram_addr_o=ld_addr_i, ram_data_o=ld_data_i, ld_ack_o=1, all in the same cycle.
  - ld_ack_o is never high without ram_write_en_o.
- ram_data_o=0 when not writing.
- LOAD:
  - fetch_hold_o=1. Each cycle with ld_req_i=1 is a write.
  - ld_done_i=1 -> RUN next cycle. If ld_req_i is also 1, the write is still performed.
  - While idle, ram_addr_o=stored_addr.
- RUN:
  - fetch_hold_o=0, ram_write_en_o=0, ram_addr_o = fetch_stall_i ? stored_addr : fetch_addr_i.
  - stored_addr <= ram_addr_o.
  - ld_req_i=1 -> WRITE next cycle. The current cycle remains a fetch read; no ack is given.
- WRITE:
  - fetch_hold_o=1.
  - ld_req_i=1 -> write performed, burst_cnt++. If burst_cnt reaches MAX_BURST after this write -> REPLAY.
  - ld_req_i=0 -> REPLAY with no write.
  - burst_cnt clears on entering REPLAY.
- REPLAY (exactly 1 cycle):
  - fetch_hold_o=1, ram_addr_o=stored_addr, read issued -> RUN.
  - A pending ld_req_i is not acked. The loader waits for at least one RUN cycle before WRITE, which guarantees fetch progress.
- instr_valid_o <= 1 if the current cycle is a read issued in RUN or REPLAY, else 0. Registered, so it aligns with ram_instr_i.
- instr_o = ram_instr_i always.
- stored_addr is unchanged in LOAD, WRITE and REPLAY.
- burst_cnt is wide enough to hold MAX_BURST; it never exceeds MAX_BURST.
- ld_done_i is ignored outside LOAD.

Test Plan:
- Reset then boot load: reset_i=0 for 2 cycles; then write 0x1111@0x0, 0x2222@0x2 with ld_req_i=1; ld_done_i on the second -> ld_ack_o high both cycles; fetch_hold_o=1 until RUN; first fetch_addr_i=0x0 gives instr_o=0x1111, instr_valid_o=1 one cycle later.
- Stall hold: in RUN fetch 0x2, then fetch_stall_i=1 for 3 cycles with fetch_addr_i=0x4 -> ram_addr_o=0x2 each cycle, instr_o=0x2222 with instr_valid_o=1 throughout.
- Mid-run write: RUN at 0x2, ld_req_i=1 for 2 writes (0xABCD@0x8, 0x1234@0xA) -> one fetch cycle, 2 ack cycles with fetch_hold_o=1, REPLAY drives ram_addr_o=0x2, instr_valid_o back to 1 the cycle after REPLAY.
- Burst cap, MAX_BURST=8: ld_req_i held for 20 cycles in RUN -> acks come as 8 writes, REPLAY, 1 RUN, then 8 more writes; never more than 8 consecutive acks.
- Reset mid-burst: reset_i=0 during the 3rd WRITE cycle -> next cycle state=LOAD, ram_write_en_o=0 while ld_req_i=0, instr_valid_o=0, fetch_hold_o=1.
- Simultaneous ld_done_i and ld_req_i in LOAD -> write acked that cycle; next cycle RUN with fetch_hold_o=0.
